// File: rtl/orbit_pixel_renderer.sv
// Pixel-colour stage: latches the orbiting body once per frame, keeps a fading
// trail of past positions and layers sprite/trail/sun/background per pixel.
module orbit_pixel_renderer #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SUN_CX      = 320,
    parameter int unsigned SUN_CY      = 240,
    parameter int unsigned SUN_R       = 24,
    parameter int unsigned SPRITE_HALF = 4,
    parameter int unsigned TRAIL_LEN   = 8,
    parameter int unsigned TRAIL_DIV   = 4,
    parameter int unsigned TRAIL_HALF  = 1,
    parameter logic [7:0]  COL_BG      = 8'h00,
    parameter logic [7:0]  COL_SUN     = 8'hFC,
    parameter logic [7:0]  COL_TRAIL   = 8'h49,
    parameter logic [7:0]  COL_SPRITE  = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] obj_x,
    input  logic [9:0] obj_y,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    output logic [7:0] color_out,
    output logic       frame_start
);

    localparam int unsigned CW    = 10;
    localparam int unsigned DW    = CW + 1;
    localparam int unsigned SW    = 22;
    localparam int unsigned PTR_W = (TRAIL_LEN > 1) ? $clog2(TRAIL_LEN) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = (TRAIL_DIV > 1) ? $clog2(TRAIL_DIV) : 1;

    // Magnitude of a signed 11-bit difference; both operands are unsigned screen coordinates.
    function automatic logic [DW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic signed [DW-1:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[DW-1] ? DW'(-d) : DW'(d);
    endfunction

    logic [CW-1:0]    prev_y;
    logic [CW-1:0]    pos_x;
    logic [CW-1:0]    pos_y;
    logic             pos_valid;
    logic [CW-1:0]    trail_x [TRAIL_LEN];
    logic [CW-1:0]    trail_y [TRAIL_LEN];
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] trail_cnt;
    logic [DIV_W-1:0] div_cnt;

    logic                 boundary_c;
    logic                 div_wrap_c;
    logic                 push_c;
    logic                 in_sprite_c;
    logic                 in_sun_c;
    logic                 in_trail_c;
    logic                 on_screen_c;
    logic [TRAIL_LEN-1:0] trail_hit_c;
    logic [DW-1:0]        sun_dx_c;
    logic [DW-1:0]        sun_dy_c;
    logic [SW-1:0]        sun_d2_c;
    logic [7:0]           pixel_c;

    assign boundary_c = (prev_y != '0) && (next_y == '0);
    assign div_wrap_c = (div_cnt == DIV_W'(TRAIL_DIV - 1));
    assign push_c     = boundary_c && div_wrap_c && pos_valid;

    assign in_sprite_c = pos_valid
                      && (abs_diff(next_x, pos_x) <= DW'(SPRITE_HALF))
                      && (abs_diff(next_y, pos_y) <= DW'(SPRITE_HALF));

    // Per-entry trail hit; entries at or beyond the fill count are stale.
    for (genvar g = 0; g < TRAIL_LEN; g++) begin : g_trail
        assign trail_hit_c[g] = (CNT_W'(g) < trail_cnt)
                             && (abs_diff(next_x, trail_x[g]) <= DW'(TRAIL_HALF))
                             && (abs_diff(next_y, trail_y[g]) <= DW'(TRAIL_HALF));
    end
    assign in_trail_c = |trail_hit_c;

    assign sun_dx_c = abs_diff(next_x, CW'(SUN_CX));
    assign sun_dy_c = abs_diff(next_y, CW'(SUN_CY));
    assign sun_d2_c = SW'(sun_dx_c) * SW'(sun_dx_c) + SW'(sun_dy_c) * SW'(sun_dy_c);
    assign in_sun_c = (sun_d2_c <= SW'(SUN_R * SUN_R));

    assign on_screen_c = (next_x < CW'(H_ACTIVE)) && (next_y < CW'(V_ACTIVE));

    // Layer priority: sprite over trail over sun over background.
    always_comb begin
        pixel_c = COL_BG;
        if (on_screen_c) begin
            if (in_sprite_c)      pixel_c = COL_SPRITE;
            else if (in_trail_c)  pixel_c = COL_TRAIL;
            else if (in_sun_c)    pixel_c = COL_SUN;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            color_out   <= COL_BG;
            frame_start <= 1'b0;
            prev_y      <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
            pos_valid   <= 1'b0;
            wr_ptr      <= '0;
            trail_cnt   <= '0;
            div_cnt     <= '0;
        end else begin
            color_out   <= pixel_c;
            frame_start <= boundary_c;
            prev_y      <= next_y;
            if (boundary_c) begin
                pos_x     <= obj_x;
                pos_y     <= obj_y;
                pos_valid <= 1'b1;
                div_cnt   <= div_wrap_c ? '0 : div_cnt + 1'b1;
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (trail_cnt != CNT_W'(TRAIL_LEN))
                    trail_cnt <= trail_cnt + 1'b1;
            end
        end
    end

    // Trail storage needs no reset; the fill count masks stale entries.
    always_ff @(posedge clock) begin
        if (push_c) begin
            trail_x[wr_ptr] <= pos_x;
            trail_y[wr_ptr] <= pos_y;
        end
    end

endmodule

// File: tb/tb_orbit_pixel_renderer.sv
// Directed bench for orbit_pixel_renderer: expected colours queued at drive
// time and checked one edge later; frames are shortened to y=1 then y=0.
module tb_orbit_pixel_renderer;

    logic       clock;
    logic       reset;
    logic [9:0] obj_x;
    logic [9:0] obj_y;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic [7:0] color_out;
    logic       frame_start;

    int unsigned total;
    int unsigned bad;
    logic [7:0]  exp_q[$];

    orbit_pixel_renderer dut (
        .clock       (clock),
        .reset       (reset),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .next_x      (next_x),
        .next_y      (next_y),
        .color_out   (color_out),
        .frame_start (frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one pixel request, then check its colour and the frame pulse after the edge.
    task automatic pix(input logic [9:0] x, input logic [9:0] y,
                       input logic [7:0] exp_col, input logic exp_fs, input string tag);
        logic [7:0] want;
        next_x = x;
        next_y = y;
        exp_q.push_back(exp_col);
        @(posedge clock);
        #1;
        want = exp_q.pop_front();
        total++;
        assert (color_out === want) else begin
            bad++;
            $error("FAIL %s (%0d,%0d): color_out=%h expected=%h", tag, x, y, color_out, want);
        end
        total++;
        assert (frame_start === exp_fs) else begin
            bad++;
            $error("FAIL %s frame_start: got=%b expected=%b", tag, frame_start, exp_fs);
        end
    endtask

    // Minimal frame: an off-screen pixel on line 1, then line 0 to form a boundary.
    task automatic frame_edge(input string tag);
        pix(10'd700, 10'd1, 8'h00, 1'b0, tag);
        pix(10'd700, 10'd0, 8'h00, 1'b1, tag);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b0;
        obj_x  = 10'd100;
        obj_y  = 10'd50;
        next_x = '0;
        next_y = '0;

        for (int i = 0; i < 3; i++) pix(10'd320, 10'd240, 8'h00, 1'b0, "in_reset");
        reset = 1'b1;

        // First frame: no pulse, no sprite, sun visible.
        pix(10'd0,   10'd0,   8'h00, 1'b0, "first_origin");
        pix(10'd320, 10'd240, 8'hFC, 1'b0, "first_sun");
        pix(10'd100, 10'd50,  8'h00, 1'b0, "first_no_sprite");
        pix(10'd639, 10'd479, 8'h00, 1'b0, "first_corner");

        frame_edge("edge1");
        pix(10'd100, 10'd50, 8'hFF, 1'b0, "spr_centre");
        pix(10'd104, 10'd54, 8'hFF, 1'b0, "spr_corner");
        pix(10'd105, 10'd50, 8'h00, 1'b0, "spr_right_out");
        pix(10'd96,  10'd46, 8'hFF, 1'b0, "spr_tl");
        pix(10'd95,  10'd46, 8'h00, 1'b0, "spr_left_out");

        obj_x = 10'd320;
        obj_y = 10'd240;
        frame_edge("edge2");
        pix(10'd320, 10'd240, 8'hFF, 1'b0, "spr_over_sun");
        pix(10'd320, 10'd264, 8'hFC, 1'b0, "sun_rim");
        pix(10'd320, 10'd265, 8'h00, 1'b0, "sun_out");
        pix(10'd337, 10'd257, 8'h00, 1'b0, "sun_diag_out");
        pix(10'd336, 10'd257, 8'hFC, 1'b0, "sun_diag_in");

        // Trail: pushes on every 4th boundary carry x=100,180,...,820 at y=100.
        obj_x = 10'd100;
        obj_y = 10'd100;
        frame_edge("edge3");
        for (int n = 4; n <= 43; n++) begin
            obj_x = 10'(100 + 20 * (n - 3));
            frame_edge("trail_edge");
        end
        pix(10'd100, 10'd100, 8'h00, 1'b0, "trail_overwritten0");
        pix(10'd180, 10'd100, 8'h00, 1'b0, "trail_overwritten1");
        pix(10'd260, 10'd100, 8'h49, 1'b0, "trail_oldest");
        pix(10'd259, 10'd101, 8'h49, 1'b0, "trail_oldest_bl");
        pix(10'd261, 10'd99,  8'h49, 1'b0, "trail_oldest_tr");
        pix(10'd262, 10'd100, 8'h00, 1'b0, "trail_dot_out");
        pix(10'd260, 10'd102, 8'h00, 1'b0, "trail_dot_below");
        pix(10'd580, 10'd100, 8'h49, 1'b0, "trail_newer");

        // Screen-edge sprite and off-screen requests.
        obj_x = 10'd639;
        obj_y = 10'd479;
        frame_edge("edge44");
        pix(10'd639, 10'd479, 8'hFF, 1'b0, "edge_sprite");
        pix(10'd635, 10'd475, 8'hFF, 1'b0, "edge_sprite_tl");
        pix(10'd634, 10'd479, 8'h00, 1'b0, "edge_sprite_out");
        pix(10'd640, 10'd479, 8'h00, 1'b0, "offscreen_x640");
        pix(10'd639, 10'd480, 8'h00, 1'b0, "offscreen_y480");
        pix(10'd700, 10'd100, 8'h00, 1'b0, "offscreen_x700");
        pix(10'd100, 10'd500, 8'h00, 1'b0, "offscreen_y500");

        // Latch cycle still renders the old position; new one shows next cycle.
        obj_x = 10'd2;
        obj_y = 10'd2;
        pix(10'd700, 10'd1, 8'h00, 1'b0, "pre_collide");
        pix(10'd0,   10'd0, 8'h00, 1'b1, "collide_old_pos");
        pix(10'd0,   10'd0, 8'hFF, 1'b0, "clip_origin");
        pix(10'd6,   10'd6, 8'hFF, 1'b0, "clip_br");
        pix(10'd7,   10'd2, 8'h00, 1'b0, "clip_right_out");
        pix(10'd639, 10'd2, 8'h00, 1'b0, "no_wrap");
        pix(10'd340, 10'd100, 8'h49, 1'b0, "trail_before_rst");

        // Mid-frame reset clears trail and hides sprite until the next boundary.
        reset = 1'b0;
        pix(10'd340, 10'd100, 8'h00, 1'b0, "midrst");
        reset = 1'b1;
        pix(10'd340, 10'd100, 8'h00, 1'b0, "post_rst_trail");
        pix(10'd2,   10'd2,   8'h00, 1'b0, "post_rst_sprite");
        pix(10'd320, 10'd240, 8'hFC, 1'b0, "post_rst_sun");
        frame_edge("post_rst_edge");
        pix(10'd2,   10'd2,   8'hFF, 1'b0, "post_edge_sprite");
        pix(10'd340, 10'd100, 8'h00, 1'b0, "post_edge_trail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
